// File: rtl/bitshifter_pkg.sv
// Shared constants and helpers for the bitshifter chip-select delay block.
package bitshifter_pkg;

  localparam int LEN_W       = 4;
  localparam int MAX_DELAY   = 15;
  localparam int DIV_DEFAULT = 16;
  localparam int N_DEFAULT   = 3;

  function automatic logic [LEN_W-1:0] len_inc(input logic [LEN_W-1:0] len);
    if (len == LEN_W'(MAX_DELAY)) begin
      len_inc = '0;
    end else begin
      len_inc = len + LEN_W'(1);
    end
  endfunction

endpackage

// File: rtl/bitshifter_btn_debounce.sv
// Push-button conditioner: sample strobe divider, 2-flop synchroniser,
// N-sample history debounce and a one-clock press pulse on each debounced rise.
module btn_debounce
  import bitshifter_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT,
  parameter int N   = N_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_stable,
  output logic sample_en,
  output logic press
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_r;
  logic             sample_en_r;
  logic [1:0]       sync_r;
  logic [N-1:0]     hist_r;
  logic [N-1:0]     hist_next_s;
  logic             btn_stable_r;
  logic             stable_d_r;
  logic             press_r;

  always_comb begin
    hist_next_s = {hist_r[N-2:0], sync_r[1]};
  end

  // Sample strobe divider and button synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= '0;
      sample_en_r <= 1'b0;
      sync_r      <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], btn_raw};
      if (cnt_r == CNT_W'(DIV - 1)) begin
        cnt_r       <= '0;
        sample_en_r <= 1'b1;
      end else begin
        cnt_r       <= cnt_r + CNT_W'(1);
        sample_en_r <= 1'b0;
      end
    end
  end

  // The stable level only moves once N consecutive samples agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_r       <= '0;
      btn_stable_r <= 1'b0;
      stable_d_r   <= 1'b0;
      press_r      <= 1'b0;
    end else begin
      if (sample_en_r) begin
        hist_r <= hist_next_s;
        if (&hist_next_s) begin
          btn_stable_r <= 1'b1;
        end else if (~|hist_next_s) begin
          btn_stable_r <= 1'b0;
        end
      end
      stable_d_r <= btn_stable_r;
      press_r    <= btn_stable_r & ~stable_d_r;
    end
  end

  assign btn_stable = btn_stable_r;
  assign sample_en  = sample_en_r;
  assign press      = press_r;

endmodule

// File: rtl/bitshifter.sv
// SPI chip-select delay: o_cs is cs delayed by len (0..15) clocks, len stepped
// by a debounced button. Define BITSHIFTER_MISO_DELAY_EN to delay sdo->miso too.
module bitshifter
  import bitshifter_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT,
  parameter int N   = N_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cs,
  input  logic sdo,
  input  logic btn_raw,
  output logic miso,
  output logic o_clk,
  output logic o_cs,
  output logic o_cs_en
);

  logic [1:0]           rst_sync_r;
  logic                 rst_int_n_s;
  logic                 btn_stable_s;
  logic                 sample_en_s;
  logic                 press_s;
  logic                 unused_s;
  logic [LEN_W-1:0]     len_r;
  logic                 o_cs_en_r;
  logic [MAX_DELAY-1:0] dl_r;
  logic                 o_cs_s;

  // Reset asserts asynchronously and releases two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_int_n_s = rst_sync_r[1];

  btn_debounce #(
    .DIV (DIV),
    .N   (N)
  ) u_deb (
    .clk        (clk),
    .rst_n      (rst_int_n_s),
    .btn_raw    (btn_raw),
    .btn_stable (btn_stable_s),
    .sample_en  (sample_en_s),
    .press      (press_s)
  );

  assign unused_s = &{1'b0, btn_stable_s, sample_en_s};

  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      len_r     <= '0;
      o_cs_en_r <= 1'b0;
      dl_r      <= '0;
    end else begin
      if (press_s) begin
        len_r <= len_inc(len_r);
      end
      o_cs_en_r <= (len_r != '0);
      dl_r      <= {dl_r[MAX_DELAY-2:0], cs};
    end
  end

  // len=0 is a combinational passthrough; otherwise tap dl[len-1].
  always_comb begin
    o_cs_s = cs;
    if (len_r != '0) begin
      o_cs_s = dl_r[len_r - LEN_W'(1)];
    end else begin
      o_cs_s = cs;
    end
  end

`ifdef BITSHIFTER_MISO_DELAY_EN
  logic [MAX_DELAY-1:0] sdl_r;
  logic                 miso_s;

  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      sdl_r <= '0;
    end else begin
      sdl_r <= {sdl_r[MAX_DELAY-2:0], sdo};
    end
  end

  always_comb begin
    miso_s = sdo;
    if (len_r != '0) begin
      miso_s = sdl_r[len_r - LEN_W'(1)];
    end else begin
      miso_s = sdo;
    end
  end

  assign miso = miso_s;
`else
  assign miso = sdo;
`endif

  assign o_cs    = o_cs_s;
  assign o_cs_en = o_cs_en_r;
  assign o_clk   = clk;

endmodule

// File: tb/tb_bitshifter.sv
// Directed self-checking bench for bitshifter (DIV=16, N=3, 50 MHz clock).
module tb_bitshifter;

  localparam int DIV = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cs = 1'b0;
  logic sdo = 1'b0;
  logic btn_raw = 1'b0;
  logic miso;
  logic o_clk;
  logic o_cs;
  logic o_cs_en;

  int checks = 0;
  int errors = 0;

  bitshifter #(.DIV(16), .N(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cs      (cs),
    .sdo     (sdo),
    .btn_raw (btn_raw),
    .miso    (miso),
    .o_clk   (o_clk),
    .o_cs    (o_cs),
    .o_cs_en (o_cs_en)
  );

  always #10 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press_btn();
    btn_raw = 1'b1;
    step(5 * DIV);
    btn_raw = 1'b0;
    step(5 * DIV);
  endtask

  // One-clock cs pulse; returns clocks until o_cs first goes high (0 = never within 20).
  task automatic measure_delay(output int d);
    d = 0;
    cs = 1'b1;
    step(1);
    cs = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      if (o_cs === 1'b1 && d == 0) d = j;
      step(1);
    end
  endtask

  int d;
  int exp_len;

  initial begin
    // Reset and idle
    step(3);
    rst_n = 1'b1;
    step(10);
    chk("reset_len", 32'(dut.len_r), 32'd0);
    chk("reset_cs_en", 32'(o_cs_en), 32'd0);
    chk("reset_stable", 32'(dut.u_deb.btn_stable_r), 32'd0);
    cs = 1'b1; #1;
    chk("pass_hi", 32'(o_cs), 32'd1);
    cs = 1'b0; #1;
    chk("pass_lo", 32'(o_cs), 32'd0);
    cs = 1'b1; #1;
    chk("pass_hi2", 32'(o_cs), 32'd1);
    cs = 1'b0; #1;
    sdo = 1'b1; #1;
    chk("miso_hi", 32'(miso), 32'd1);
    sdo = 1'b0; #1;
    chk("miso_lo", 32'(miso), 32'd0);
    chk("o_clk", 32'(o_clk), 32'(clk));

    // Bouncy press: four 1-clk toggles, 3 samples high, 2 low
    for (int i = 0; i < 4; i++) begin
      btn_raw = 1'b1; step(1);
      btn_raw = 1'b0; step(1);
    end
    btn_raw = 1'b1;
    step(3 * DIV);
    btn_raw = 1'b0;
    step(2 * DIV);
    step(2 * DIV + 4);
    chk("bounce_len", 32'(dut.len_r), 32'd1);
    chk("bounce_cs_en", 32'(o_cs_en), 32'd1);
    step(5 * DIV);
    chk("bounce_once", 32'(dut.len_r), 32'd1);

    // len=1: single-clock cs pulse
    cs = 1'b1; #1;
    chk("len1_pre", 32'(o_cs), 32'd0);
    step(1);
    cs = 1'b0;
    #1;
    chk("len1_first", 32'(o_cs), 32'd1);
    step(1);
    chk("len1_next", 32'(o_cs), 32'd0);
    step(4);
    measure_delay(d);
    chk("delay_1", 32'(d), 32'd1);

    // Fifteen more presses: 2..15 then wrap to 0
    exp_len = 1;
    for (int i = 0; i < 15; i++) begin
      press_btn();
      exp_len = (exp_len + 1) % 16;
      chk("step_len", 32'(dut.len_r), 32'(exp_len));
      if (exp_len == 7) begin
        measure_delay(d);
        chk("delay_7", 32'(d), 32'd7);
      end
      if (exp_len == 15) begin
        chk("len15_cs_en", 32'(o_cs_en), 32'd1);
        measure_delay(d);
        chk("delay_15", 32'(d), 32'd15);
      end
    end
    chk("wrap_cs_en", 32'(o_cs_en), 32'd0);
    cs = 1'b1; #1;
    chk("wrap_pass", 32'(o_cs), 32'd1);
    cs = 1'b0; #1;

    // Glitch of one sample period is ignored
    btn_raw = 1'b1;
    step(DIV);
    btn_raw = 1'b0;
    step(3);
    chk("glitch_stable_mid", 32'(dut.u_deb.btn_stable_r), 32'd0);
    step(5 * DIV);
    chk("glitch_len", 32'(dut.len_r), 32'd0);
    chk("glitch_stable", 32'(dut.u_deb.btn_stable_r), 32'd0);

    // len=7 then reset mid-pattern
    for (int i = 0; i < 7; i++) press_btn();
    chk("len7", 32'(dut.len_r), 32'd7);
    cs = 1'b1; step(1);
    cs = 1'b0; step(1);
    cs = 1'b1; step(1);
    cs = 1'b1; step(1);
    #4;
    rst_n = 1'b0;
    #1;
    chk("rst_len", 32'(dut.len_r), 32'd0);
    chk("rst_dl", 32'(dut.dl_r), 32'd0);
    chk("rst_cs_en", 32'(o_cs_en), 32'd0);
    chk("rst_pass_hi", 32'(o_cs), 32'd1);
    cs = 1'b0; #1;
    chk("rst_pass_lo", 32'(o_cs), 32'd0);
    step(3);
    rst_n = 1'b1;
    step(5);
    chk("post_rst_len", 32'(dut.len_r), 32'd0);
    cs = 1'b1; #1;
    chk("post_rst_pass", 32'(o_cs), 32'd1);
    cs = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
